// File: rtl/obuf_pkg.sv
// Shared defaults, element/row types and the FIFO count-width helper for the output buffer.
package obuf_pkg;

   localparam int DEF_ARRAY_SIZE = 4;
   localparam int DEF_DATA_W     = 32;

   typedef logic [DEF_DATA_W-1:0] elem_t;
   typedef elem_t [DEF_ARRAY_SIZE-1:0] row_t;

   // Count must represent 0..DEPTH inclusive, hence one bit more than the pointers.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/obuf_drain_if.sv
// Column-result input and row-stream output bundle of the output buffer.
interface obuf_drain_if #(
   parameter int ARRAY_SIZE = obuf_pkg::DEF_ARRAY_SIZE,
   parameter int DATA_W     = obuf_pkg::DEF_DATA_W
);
   logic [ARRAY_SIZE-1:0]             col_valid_in;
   logic [ARRAY_SIZE-1:0][DATA_W-1:0] col_data_in;
   logic                              row_valid_out;
   logic                              row_ready_in;
   logic [ARRAY_SIZE-1:0][DATA_W-1:0] row_data_out;
   logic                              row_last_out;
   logic                              stall_out;
   logic                              overflow_err;

   modport master (
      output col_valid_in, col_data_in, row_ready_in,
      input  row_valid_out, row_data_out, row_last_out, stall_out, overflow_err
   );

   modport slave (
      input  col_valid_in, col_data_in, row_ready_in,
      output row_valid_out, row_data_out, row_last_out, stall_out, overflow_err
   );
endinterface

// File: rtl/obuf_col_fifo.sv
// Single-column synchronous FIFO; head entry is readable in the same cycle it is popped.
module obuf_col_fifo
   import obuf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 8,
   parameter int CW     = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic              wr_en;
   logic              rd_en;

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign dout  = mem[rd_ptr_reg];

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/obuf_drain.sv
// Output buffer: realigns skewed column results into rows on a valid/ready stream.
// Build option OBUF_ZERO_SKIP_EN drops all-zero rows except the last row of each tile.
module obuf_drain
   import obuf_pkg::*;
#(
   parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH      = 8
) (
   input logic         clk,
   input logic         RST,
   obuf_drain_if.slave bus
);
   localparam int              CW        = cnt_w(DEPTH);
   localparam int              RW        = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam logic [RW-1:0]   LAST_IDX  = RW'(ARRAY_SIZE - 1);
   localparam logic [CW-1:0]   STALL_LVL = CW'(DEPTH - ARRAY_SIZE);

   logic [ARRAY_SIZE-1:0][DATA_W-1:0] head;
   logic [ARRAY_SIZE-1:0]             empty;
   logic [ARRAY_SIZE-1:0]             full;
   logic [ARRAY_SIZE-1:0]             busy;
   logic [CW-1:0]                     cnt [ARRAY_SIZE];
   logic                              form;
   logic                              skip;
   logic                              load;
   logic                              xfer;

   logic                              row_valid_reg;
   logic                              row_last_reg;
   logic                              overflow_reg;
   logic [ARRAY_SIZE-1:0][DATA_W-1:0] row_data_reg;
   logic [RW-1:0]                     row_idx_reg;

   genvar gi;
   generate
      for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_col
         obuf_col_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .srst  (RST),
            .push  (bus.col_valid_in[gi]),
            .pop   (form),
            .din   (bus.col_data_in[gi]),
            .dout  (head[gi]),
            .full  (full[gi]),
            .empty (empty[gi]),
            .count (cnt[gi])
         );
         // Fewer than ARRAY_SIZE free slots cannot absorb the in-flight skew.
         assign busy[gi] = (cnt[gi] > STALL_LVL);
      end
   endgenerate

   assign xfer = row_valid_reg && bus.row_ready_in;
   assign form = (~|empty) && (!row_valid_reg || bus.row_ready_in);

`ifdef OBUF_ZERO_SKIP_EN
   assign skip = (head == '0) && (row_idx_reg != LAST_IDX);
`else
   assign skip = 1'b0;
`endif

   assign load = form && !skip;

   always_ff @(posedge clk) begin
      if (RST) begin
         row_valid_reg <= 1'b0;
         row_last_reg  <= 1'b0;
         row_data_reg  <= '0;
         row_idx_reg   <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         if (form) begin
            row_idx_reg <= (row_idx_reg == LAST_IDX) ? '0 : row_idx_reg + 1'b1;
         end
         if (load) begin
            row_valid_reg <= 1'b1;
            row_data_reg  <= head;
            row_last_reg  <= (row_idx_reg == LAST_IDX);
         end else if (xfer) begin
            row_valid_reg <= 1'b0;
         end
         overflow_reg <= overflow_reg | (|(bus.col_valid_in & full & ~{ARRAY_SIZE{form}}));
      end
   end

   assign bus.row_valid_out = row_valid_reg;
   assign bus.row_data_out  = row_data_reg;
   assign bus.row_last_out  = row_last_reg;
   assign bus.stall_out     = |busy;
   assign bus.overflow_err  = overflow_reg;

endmodule
